// File: rtl/stream_arb_mux.sv
// stream_arb_mux: registered N-to-1 stream mux with fixed/round-robin grant and packet locking.
// Optional MUX_CHANNEL_TAG_EN adds outchannel, the source index registered with each beat.
module stream_arb_mux #(
  parameter int BUSWIDTH    = 8,
  parameter int CHANNELS    = 4,
  parameter int CHANNELBITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*BUSWIDTH-1:0] inlines,
  input  logic [CHANNELS-1:0]          invalid,
  input  logic [CHANNELS-1:0]          inlast,
  output logic [CHANNELS-1:0]          inready,
  input  logic                         arb_mode,
  input  logic [CHANNELBITS-1:0]       channel,
  output logic [BUSWIDTH-1:0]          outlines,
  output logic                         outvalid,
  output logic                         outlast,
`ifdef MUX_CHANNEL_TAG_EN
  output logic [CHANNELBITS-1:0]       outchannel,
`endif
  input  logic                         outready
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [CHANNELBITS-1:0] grant, rr_ptr, rr_lo, rr_hi, cand, next_ptr;
  logic hi_hit, fix_hit, active, load, xfer, beat_last;
  logic [BUSWIDTH-1:0] beat_data;
  // Round-robin: lowest valid at or above rr_ptr, else lowest valid overall (wrap).
  always_comb begin
    rr_lo = '0;
    rr_hi = '0;
    hi_hit = 1'b0;
    fix_hit = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (invalid[k]) rr_lo = CHANNELBITS'(k);
      if (invalid[k] && CHANNELBITS'(k) >= rr_ptr) begin
        rr_hi = CHANNELBITS'(k);
        hi_hit = 1'b1;
      end
      if (invalid[k] && channel == CHANNELBITS'(k)) fix_hit = 1'b1;
    end
  end
  assign cand     = (state == LOCKED) ? grant : arb_mode ? (hi_hit ? rr_hi : rr_lo) : channel;
  assign active   = (state == LOCKED) | (arb_mode ? |invalid : fix_hit);
  assign load     = !outvalid | outready;
  assign next_ptr = (cand == CHANNELBITS'(CHANNELS - 1)) ? '0 : cand + CHANNELBITS'(1);
  assign xfer     = |(inready & invalid);
  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    inready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cand == CHANNELBITS'(k)) begin
        beat_data = inlines[k*BUSWIDTH +: BUSWIDTH];
        beat_last = inlast[k];
        inready[k] = rst_n & load & active;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
      outlines <= '0;
      outvalid <= 1'b0;
      outlast <= 1'b0;
`ifdef MUX_CHANNEL_TAG_EN
      outchannel <= '0;
`endif
    end else begin
      if (load) outvalid <= xfer;
      if (xfer) begin
        outlines <= beat_data;
        outlast <= beat_last;
        grant <= cand;
`ifdef MUX_CHANNEL_TAG_EN
        outchannel <= cand;
`endif
        if (beat_last) rr_ptr <= next_ptr;
        state <= beat_last ? IDLE : LOCKED;
      end
    end
  end
endmodule

// File: tb/tb_stream_arb_mux.sv
// tb_stream_arb_mux: directed and random stimulus against a packet-level reference model.
module tb_stream_arb_mux;
  localparam int BW = 8, N = 4, CB = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [N*BW-1:0] inlines;
  logic [N-1:0] invalid, inlast, inready;
  logic arb_mode, outvalid, outlast, outready;
  logic [CB-1:0] channel;
  logic [BW-1:0] outlines;
  logic [3*BW-1:0] in3;
  logic [2:0] inv3, inl3, inready3;
  logic [BW-1:0] out3;
  logic ov3, ol3;
`ifdef MUX_CHANNEL_TAG_EN
  logic [CB-1:0] outchannel, oc3;
`endif
  assign in3  = inlines[3*BW-1:0];
  assign inv3 = invalid[2:0];
  assign inl3 = inlast[2:0];

  stream_arb_mux #(.BUSWIDTH(BW), .CHANNELS(N), .CHANNELBITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .inlines(inlines), .invalid(invalid), .inlast(inlast),
    .inready(inready), .arb_mode(arb_mode), .channel(channel), .outlines(outlines),
    .outvalid(outvalid), .outlast(outlast),
`ifdef MUX_CHANNEL_TAG_EN
    .outchannel(outchannel),
`endif
    .outready(outready));

  // Three channels with channel=3 selected: nothing may ever be granted.
  stream_arb_mux #(.BUSWIDTH(BW), .CHANNELS(3), .CHANNELBITS(CB)) dut3 (
    .clk(clk), .rst_n(rst_n), .inlines(in3), .invalid(inv3), .inlast(inl3),
    .inready(inready3), .arb_mode(1'b0), .channel(2'd3), .outlines(out3),
    .outvalid(ov3), .outlast(ol3),
`ifdef MUX_CHANNEL_TAG_EN
    .outchannel(oc3),
`endif
    .outready(outready));

  int vectors = 0, miscompares = 0;
  int lock, rr;
  logic mv, ml;
  logic [BW-1:0] md;
  int mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lock = -1; rr = 0; mv = 1'b0; ml = 1'b0; md = '0; mc = 0;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic m,
                       input logic [CB-1:0] c, input logic r);
    invalid = v; inlast = l; arb_mode = m; channel = c; outready = r;
    inlines = $urandom;
  endtask

  // Called at a falling edge with inputs applied; checks, advances the model, waits one cycle.
  task automatic step();
    int cand;
    bit act, load, x;
    logic [N-1:0] er;
    #1;
    load = !mv || outready;
    act = 1'b0;
    cand = 0;
    if (lock >= 0) begin
      cand = lock; act = 1'b1;
    end else if (arb_mode) begin
      for (int i = N - 1; i >= 0; i--)
        if (invalid[(rr + i) % N]) begin cand = (rr + i) % N; act = 1'b1; end
    end else begin
      cand = int'(channel);
      act = (cand < N) && invalid[cand];
    end
    er = '0;
    if (load && act) er[cand] = 1'b1;
    chk("outvalid", 32'(outvalid), 32'(mv));
    if (mv) begin
      chk("outlines", 32'(outlines), 32'(md));
      chk("outlast", 32'(outlast), 32'(ml));
`ifdef MUX_CHANNEL_TAG_EN
      chk("outchannel", 32'(outchannel), 32'(mc));
`endif
    end
    chk("inready", 32'(inready), 32'(er));
    chk("oob_inready", 32'(inready3), 32'd0);
    chk("oob_outvalid", 32'(ov3), 32'd0);
    x = act && load && invalid[cand];
    if (load) mv = x;
    if (x) begin
      md = inlines[cand*BW +: BW];
      ml = inlast[cand];
      mc = cand;
      if (inlast[cand]) begin lock = -1; rr = (cand + 1) % N; end
      else lock = cand;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_outvalid", 32'(outvalid), 32'd0);
    chk("rst_outlines", 32'(outlines), 32'd0);
    chk("rst_outlast", 32'(outlast), 32'd0);
    chk("rst_inready", 32'(inready), 32'd0);
    rst_n = 1'b1;
    // Round-robin over four single-beat sources
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1);
      inlines = {8'h33, 8'h32, 8'h31, 8'h30};
      step();
      chk("rr_order", 32'(outlines), 32'(8'h30 + i % 4));
    end
    // Fixed ch2 three-beat packet; channel moved to 1 mid-packet
    drive(4'b1111, 4'b0000, 1'b0, 2'd2, 1'b1); inlines[23:16] = 8'hA1; step();
    chk("fix_a1", 32'(outlines), 32'hA1);
    drive(4'b1111, 4'b0000, 1'b0, 2'd1, 1'b1); inlines[23:16] = 8'hA2; step();
    chk("fix_a2", 32'(outlines), 32'hA2);
    drive(4'b1111, 4'b0100, 1'b0, 2'd1, 1'b1); inlines[23:16] = 8'hA3; step();
    chk("fix_a3", 32'(outlines), 32'hA3);
    chk("fix_a3_last", 32'(outlast), 32'd1);
    drive(4'b1111, 4'b0010, 1'b0, 2'd1, 1'b1); inlines[15:8] = 8'hB1; step();
    chk("fix_ch1", 32'(outlines), 32'hB1);
    // rr_ptr is 2: ch3 first, then wrap to ch1
    for (int i = 0; i < 2; i++) begin
      drive(4'b1010, 4'b1010, 1'b1, 2'd0, 1'b1);
      inlines[31:24] = 8'hD3; inlines[15:8] = 8'hD1;
      step();
      chk("rr_wrap", 32'(outlines), (i == 0) ? 32'hD3 : 32'hD1);
    end
    // Backpressure hold
    drive(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1); inlines[7:0] = 8'h5C; step();
    chk("bp_load", 32'(outlines), 32'h5C);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0); inlines[7:0] = 8'h77; step();
      chk("bp_hold", 32'(outlines), 32'h5C);
      chk("bp_inready", 32'(inready), 32'd0);
    end
    drive(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1); inlines[7:0] = 8'h77; step();
    chk("bp_next", 32'(outlines), 32'h77);
    drive(4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1); step();
    // Random traffic, mode and channel churn, random backpressure
    begin
      logic m = 1'b1;
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(15) == 0) m = ~m;
        drive(4'($urandom), 4'($urandom & $urandom), m, 2'($urandom), $urandom_range(3) != 0);
        step();
      end
    end
    // Asynchronous reset in the middle of a packet
    drive(4'b1111, 4'b0000, 1'b1, 2'd0, 1'b1); step();
    drive(4'b1111, 4'b0000, 1'b1, 2'd0, 1'b1); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outvalid", 32'(outvalid), 32'd0);
    chk("arst_outlines", 32'(outlines), 32'd0);
    chk("arst_inready", 32'(inready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 2'd0, 1'b1); inlines = {8'hE3, 8'hE2, 8'hE1, 8'hE0}; step();
    chk("arst_first", 32'(outlines), 32'hE0);
    drive(4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
